// File: rtl/decode_instr_queue_pkg.sv
// Shared configuration for the decode instruction queue: default sizes and packet layout.
package decode_instr_queue_pkg;

  localparam int I_SIZE             = 32;
  localparam int DECODE_QUEUE_DEPTH = 4;
  localparam int DECODE_QUEUE_IMM_W = I_SIZE - 16;

  // Packet is {instr_l, imm, jmp_pred}; every concatenation uses this width.
  function automatic int pkt_width(input int instr_w, input int imm_w);
    return instr_w + imm_w + 1;
  endfunction

endpackage

// File: rtl/decode_queue_mem.sv
// Packet storage for the decode queue: one write port, one asynchronous read port, no reset.
module decode_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/decode_instr_queue.sv
// Multi-entry in-order instruction queue between fetch and decode.
// Optional same-cycle bypass when empty is enabled by DECODE_QUEUE_BYPASS_EN.
module decode_instr_queue
  import decode_instr_queue_pkg::*;
#(
  parameter int DEPTH   = DECODE_QUEUE_DEPTH,
  parameter int INSTR_W = 16,
  parameter int IMM_W   = DECODE_QUEUE_IMM_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [INSTR_W-1:0] i_instr_l,
  input  logic [IMM_W-1:0]   i_imm_pass,
  input  logic               i_jmp_pred_pass,
  input  logic               i_submit,
  output logic               o_ready,
  input  logic               i_next_ready,
  output logic               o_submit,
  output logic [INSTR_W-1:0] o_instr_l,
  output logic [IMM_W-1:0]   o_imm_pass,
  output logic               o_jmp_pred_pass,
  input  logic               i_flush,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PKT_W = pkt_width(INSTR_W, IMM_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PKT_W-1:0] in_pkt;
  logic [PKT_W-1:0] head_pkt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             store;

  assign in_pkt  = {i_instr_l, i_imm_pass, i_jmp_pred_pass};
  assign full    = (o_count == FULL_CNT);
  assign empty   = (o_count == '0);
  assign o_ready = ~full;
  assign push    = i_submit & ~full & ~i_flush;
  assign pop     = ~empty & i_next_ready & ~i_flush;

`ifdef DECODE_QUEUE_BYPASS_EN
  // An empty queue with a ready consumer forwards the incoming packet without storing it.
  logic bypass;
  assign bypass = empty & i_submit & i_next_ready & ~i_flush;
  assign store  = push & ~bypass;
`else
  assign store  = push;
`endif

  decode_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_mem (
    .clk   (i_clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (in_pkt),
    .raddr (rd_ptr),
    .rdata (head_pkt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_submit   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_submit <= 1'b0;
      if (i_submit & full) o_overflow <= 1'b1;
      if (i_flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        o_count <= '0;
      end else begin
        if (store) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (store & ~pop) o_count <= o_count + 1'b1;
        else if (~store & pop) o_count <= o_count - 1'b1;
        if (pop) o_submit <= 1'b1;
`ifdef DECODE_QUEUE_BYPASS_EN
        if (bypass) o_submit <= 1'b1;
`endif
      end
    end
  end

  // Output data registers hold between pops and carry no reset.
  always_ff @(posedge i_clk) begin
    if (pop) begin
      {o_instr_l, o_imm_pass, o_jmp_pred_pass} <= head_pkt;
`ifdef DECODE_QUEUE_BYPASS_EN
    end else if (bypass) begin
      {o_instr_l, o_imm_pass, o_jmp_pred_pass} <= in_pkt;
`endif
    end
  end

endmodule
